// File: rtl/fp_div_norm_round.sv
// FP divide post-stage: normalizes the raw quotient one bit per cycle, rounds to nearest-even, packs IEEE-754 single.
// Optional FP_NORM_FLAGS_EN adds the registered {overflow, underflow, inexact} output.
module fp_div_norm_round #(
    parameter int unsigned MW   = 24,
    parameter int unsigned QW   = MW + 2,
    parameter int unsigned EW   = 8,
    parameter int unsigned EMAX = (1 << EW) - 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sign,
    input  logic [EW+1:0]    in_exp,
    input  logic [QW-1:0]    in_quot,
    input  logic             in_rem_nz,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [EW+MW-1:0] out_result
`ifdef FP_NORM_FLAGS_EN
    ,
    output logic [2:0]       out_flags
`endif
);

    localparam int unsigned XW = EW + 2;
    localparam int unsigned RW = EW + MW;

    typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

    state_t          state, state_nxt;
    logic            sign_q;
    logic [XW-1:0]   exp_q;
    logic [QW-1:0]   quot_q;
    logic            sticky_q;

    logic            accept;
    logic            round_bit, sticky_bit, inc, carry, ovf, unf;
    logic [MW-1:0]   frac_sum;
    logic [XW-1:0]   exp_r;
    logic [RW-1:0]   res_round;
    logic            in_ready_d, out_valid_d;
    logic [RW-1:0]   result_d;
`ifdef FP_NORM_FLAGS_EN
    logic [2:0]      flags_round, flags_d;
`endif

    assign accept = in_valid & in_ready;

    // State register
    always_ff @(posedge clk) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    if (in_quot == '0) state_nxt = DONE;
                    else               state_nxt = NORM;
                end
            end
            NORM:    if (quot_q[QW-1]) state_nxt = ROUND;
            ROUND:   state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Round-to-nearest-even on the fraction only; a carry out means the mantissa wrapped to 1.0
    always_comb begin
        round_bit  = quot_q[1];
        sticky_bit = quot_q[0] | sticky_q;
        inc        = round_bit & (sticky_bit | quot_q[2]);
        frac_sum   = {1'b0, quot_q[QW-2:2]} + MW'(inc);
        carry      = frac_sum[MW-1];
        exp_r      = exp_q + XW'(carry);
        ovf        = !exp_r[XW-1] && (exp_r >= XW'(EMAX));
        unf        = !ovf && (exp_r[XW-1] || (exp_r == '0));
        if (ovf)      res_round = {sign_q, {EW{1'b1}}, (MW-1)'(0)};
        else if (unf) res_round = {sign_q, (RW-1)'(0)};
        else          res_round = {sign_q, exp_r[EW-1:0], frac_sum[MW-2:0]};
`ifdef FP_NORM_FLAGS_EN
        flags_round = {ovf, unf, round_bit | sticky_bit | ovf | unf};
`endif
    end

    // Output next-values
    always_comb begin
        in_ready_d  = (state_nxt == IDLE);
        out_valid_d = (state_nxt == DONE);
        result_d    = out_result;
`ifdef FP_NORM_FLAGS_EN
        flags_d     = out_flags;
`endif
        if ((state == IDLE) && accept && (in_quot == '0)) begin
            result_d = {in_sign, (RW-1)'(0)};
`ifdef FP_NORM_FLAGS_EN
            flags_d  = '0;
`endif
        end else if (state == ROUND) begin
            result_d = res_round;
`ifdef FP_NORM_FLAGS_EN
            flags_d  = flags_round;
`endif
        end
    end

    // Registered outputs and datapath
    always_ff @(posedge clk) begin
        if (!rstn) begin
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            out_result <= '0;
`ifdef FP_NORM_FLAGS_EN
            out_flags  <= '0;
`endif
            sign_q     <= 1'b0;
            exp_q      <= '0;
            quot_q     <= '0;
            sticky_q   <= 1'b0;
        end else begin
            in_ready   <= in_ready_d;
            out_valid  <= out_valid_d;
            out_result <= result_d;
`ifdef FP_NORM_FLAGS_EN
            out_flags  <= flags_d;
`endif
            if ((state == IDLE) && accept) begin
                sign_q   <= in_sign;
                exp_q    <= in_exp;
                quot_q   <= in_quot;
                sticky_q <= in_rem_nz;
            end else if ((state == NORM) && !quot_q[QW-1]) begin
                quot_q <= {quot_q[QW-2:0], 1'b0};
                exp_q  <= exp_q - XW'(1);
            end
        end
    end

endmodule
